// File: rtl/branch_pkg.sv
// Shared types for the branch sequencer: operation, condition mode and FSM state.
package branch_pkg;

  typedef enum logic [1:0] {
    OP_STEP = 2'd0,
    OP_JUMP = 2'd1,
    OP_CALL = 2'd2,
    OP_RET  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    MODE_ALWAYS = 2'd0,
    MODE_ANY    = 2'd1,
    MODE_ALL    = 2'd2,
    MODE_NONE   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EVAL   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/branch_sequencer_if.sv
// Request/status bundle between a controller (master) and the branch sequencer (slave).
interface branch_sequencer_if
  import branch_pkg::*;
#(
  parameter int PC_W   = 16,
  parameter int FLAG_W = 8
);

  logic              rx_enable;
  logic              rx_strobe;
  op_t               rx_op;
  mode_t             rx_mode;
  logic              rx_relative;
  logic [FLAG_W-1:0] rx_check_flags;
  logic [FLAG_W-1:0] rx_input_flags;
  logic [PC_W-1:0]   rx_target;
  logic [PC_W-1:0]   tx_program_counter;
  logic              tx_ready;
  logic              tx_taken;
  logic              tx_overflow;
  logic              tx_underflow;

  modport master (
    output rx_enable, rx_strobe, rx_op, rx_mode, rx_relative,
           rx_check_flags, rx_input_flags, rx_target,
    input  tx_program_counter, tx_ready, tx_taken, tx_overflow, tx_underflow
  );

  modport slave (
    input  rx_enable, rx_strobe, rx_op, rx_mode, rx_relative,
           rx_check_flags, rx_input_flags, rx_target,
    output tx_program_counter, tx_ready, tx_taken, tx_overflow, tx_underflow
  );

endinterface

// File: rtl/branch_return_stack.sv
// LIFO of return addresses. Push on full and pop on empty are ignored;
// the caller decides what those attempts mean.
module branch_return_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   count;
  logic [PTR_W-1:0] top_idx;
  logic [WIDTH-1:0] mem [DEPTH];

  // Top entry sits one below the fill count; DEPTH is a power of two so the
  // low bits of a full count wrap to zero and the subtraction lands on DEPTH-1.
  assign top_idx  = count[PTR_W-1:0] - {{(PTR_W-1){1'b0}}, 1'b1};
  assign pop_data = mem[top_idx];
  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);

  // Fill count; only a successful push or pop moves it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + {{PTR_W{1'b0}}, 1'b1};
    end else if (pop && !empty) begin
      count <= count - {{PTR_W{1'b0}}, 1'b1};
    end
  end

  // Storage needs no reset: entries are only read below the fill count.
  always_ff @(posedge aclk) begin
    if (push && !full) begin
      mem[count[PTR_W-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/branch_sequencer.sv
// Program-counter sequencer: executes one STEP/JUMP/CALL/RET per accepted strobe,
// with flag-conditioned branches and a small return-address stack.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ready; a strobe captures the request
// EVAL   | two phases: snapshot masked flags, then resolve the condition
// COMMIT | single PC update, stack push/pop, sticky error flags
module branch_sequencer
  import branch_pkg::*;
#(
  parameter int PC_W        = 16,
  parameter int FLAG_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input logic               aclk,
  input logic               aresetn,
  branch_sequencer_if.slave bus
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic              en_q;
  logic [FLAG_W-1:0] flags_q;
  state_t            state;
  logic              eval_ph;
  op_t               op_q;
  mode_t             mode_q;
  logic              rel_q;
  logic [FLAG_W-1:0] mask_q;
  logic [FLAG_W-1:0] masked_q;
  logic [PC_W-1:0]   target_q;
  logic [PC_W-1:0]   pc_q;
  logic              cond_q;
  logic              taken_q;
  logic              ovf_q;
  logic              unf_q;

  logic              commit;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   jump_pc;
  logic [PC_W-1:0]   pc_next;
  logic              commit_taken;
  logic              set_ovf;
  logic              set_unf;
  logic              push;
  logic              pop;
  logic [PC_W-1:0]   pop_data;
  logic              full;
  logic              empty;

  function automatic logic cond_eval(input mode_t mode,
                                     input logic [FLAG_W-1:0] masked,
                                     input logic [FLAG_W-1:0] mask);
    case (mode)
      MODE_ALWAYS: return 1'b1;
      MODE_ANY:    return |masked;
      MODE_ALL:    return masked == mask;
      default:     return ~|masked;
    endcase
  endfunction

  branch_return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (PC_W)
  ) u_stack (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty)
  );

  assign commit  = en_q && (state == S_COMMIT);
  assign pc_inc  = pc_q + PC_ONE;
  assign jump_pc = rel_q ? (pc_q + target_q) : target_q;

  // Resolve the committed operation: next PC, stack action, pulse and error flags.
  always_comb begin
    pc_next      = pc_inc;
    push         = 1'b0;
    pop          = 1'b0;
    commit_taken = 1'b0;
    set_ovf      = 1'b0;
    set_unf      = 1'b0;
    if (commit) begin
      case (op_q)
        OP_JUMP: begin
          if (cond_q) begin
            pc_next      = jump_pc;
            commit_taken = 1'b1;
          end
        end
        OP_CALL: begin
          if (cond_q) begin
            if (full) begin
              set_ovf = 1'b1;
            end else begin
              push         = 1'b1;
              pc_next      = jump_pc;
              commit_taken = 1'b1;
            end
          end
        end
        OP_RET: begin
          if (empty) begin
            set_unf = 1'b1;
          end else begin
            pop          = 1'b1;
            pc_next      = pop_data;
            commit_taken = 1'b1;
          end
        end
        default: pc_next = pc_inc;
      endcase
    end
  end

  // Enable synchroniser runs freely; everything else advances only while it is high.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      en_q <= 1'b0;
    end else begin
      en_q <= bus.rx_enable;
    end
  end

  // Sequencer FSM, request capture, PC and status flags.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      flags_q  <= '0;
      state    <= S_IDLE;
      eval_ph  <= 1'b0;
      op_q     <= OP_STEP;
      mode_q   <= MODE_ALWAYS;
      rel_q    <= 1'b0;
      mask_q   <= '0;
      masked_q <= '0;
      target_q <= '0;
      pc_q     <= '0;
      cond_q   <= 1'b0;
      taken_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else if (en_q) begin
      flags_q <= bus.rx_input_flags;
      taken_q <= commit_taken;
      if (set_ovf) ovf_q <= 1'b1;
      if (set_unf) unf_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (bus.rx_strobe) begin
            op_q     <= bus.rx_op;
            mode_q   <= bus.rx_mode;
            rel_q    <= bus.rx_relative;
            mask_q   <= bus.rx_check_flags;
            target_q <= bus.rx_target;
            eval_ph  <= 1'b0;
            state    <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (!eval_ph) begin
            masked_q <= flags_q & mask_q;
            eval_ph  <= 1'b1;
          end else begin
            cond_q <= cond_eval(mode_q, masked_q, mask_q);
            state  <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          pc_q  <= pc_next;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.tx_program_counter = pc_q;
  assign bus.tx_ready           = (state == S_IDLE);
  assign bus.tx_taken           = taken_q;
  assign bus.tx_overflow        = ovf_q;
  assign bus.tx_underflow       = unf_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer with hand-computed expected PCs.
module tb_branch_sequencer;
  import branch_pkg::*;

  logic aclk = 1'b0;
  logic aresetn;
  int   n_checks = 0;
  int   n_fail   = 0;

  branch_sequencer_if #(.PC_W(16), .FLAG_W(8)) sif ();

  branch_sequencer #(.PC_W(16), .FLAG_W(8), .STACK_DEPTH(4)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (sif)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // One operation; strobe accepted on the next rising edge, PC checked 2 and 3 edges later.
  task automatic run_op(input op_t op, input mode_t mode, input logic rel,
                        input logic [7:0] mask, input logic [15:0] target,
                        input logic [15:0] old_pc, input logic [15:0] new_pc,
                        input logic exp_taken, input string name);
    @(negedge aclk);
    n_checks++;
    if (sif.tx_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_before: got %b expected 1", name, sif.tx_ready);
    end
    sif.rx_strobe = 1'b1; sif.rx_op = op; sif.rx_mode = mode; sif.rx_relative = rel;
    sif.rx_check_flags = mask; sif.rx_target = target;
    @(posedge aclk);
    @(negedge aclk);
    sif.rx_strobe = 1'b0;
    n_checks++;
    if (sif.tx_ready !== 1'b0) begin
      n_fail++; $display("FAIL %s ready_c1: got %b expected 0", name, sif.tx_ready);
    end
    @(negedge aclk);
    n_checks++;
    if (sif.tx_ready !== 1'b0) begin
      n_fail++; $display("FAIL %s ready_c2: got %b expected 0", name, sif.tx_ready);
    end
    @(negedge aclk);
    n_checks++;
    if (sif.tx_ready !== 1'b0 || sif.tx_program_counter !== old_pc) begin
      n_fail++; $display("FAIL %s early: ready %b pc %h, expected ready 0 pc %h", name, sif.tx_ready, sif.tx_program_counter, old_pc);
    end
    @(negedge aclk);
    n_checks++;
    if (sif.tx_program_counter !== new_pc) begin
      n_fail++; $display("FAIL %s pc: got %h expected %h", name, sif.tx_program_counter, new_pc);
    end
    n_checks++;
    if (sif.tx_ready !== 1'b1 || sif.tx_taken !== exp_taken) begin
      n_fail++; $display("FAIL %s taken/ready: got taken %b ready %b expected taken %b ready 1", name, sif.tx_taken, sif.tx_ready, exp_taken);
    end
    @(negedge aclk);
    n_checks++;
    if (sif.tx_taken !== 1'b0 || sif.tx_program_counter !== new_pc) begin
      n_fail++; $display("FAIL %s after: taken %b pc %h, expected taken 0 pc %h", name, sif.tx_taken, sif.tx_program_counter, new_pc);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    sif.rx_enable = 1'b1; sif.rx_strobe = 1'b0; sif.rx_op = OP_STEP; sif.rx_mode = MODE_ALWAYS;
    sif.rx_relative = 1'b0; sif.rx_check_flags = '0; sif.rx_input_flags = '0; sif.rx_target = '0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    n_checks++;
    if (sif.tx_program_counter !== 16'h0000) begin
      n_fail++; $display("FAIL reset_pc: got %h expected 0000", sif.tx_program_counter);
    end
    aresetn = 1'b1;
    @(negedge aclk);
    n_checks++;
    if (sif.tx_ready !== 1'b1 || sif.tx_taken !== 1'b0 || sif.tx_overflow !== 1'b0 || sif.tx_underflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: ready %b taken %b ovf %b unf %b, expected 1 0 0 0", sif.tx_ready, sif.tx_taken, sif.tx_overflow, sif.tx_underflow);
    end
    @(negedge aclk);
  endtask

  task automatic test_step();
    run_op(OP_STEP, MODE_ALWAYS, 1'b0, 8'h00, 16'h0000, 16'h0000, 16'h0001, 1'b0, "step1");
    run_op(OP_STEP, MODE_ALWAYS, 1'b0, 8'h00, 16'h0000, 16'h0001, 16'h0002, 1'b0, "step2");
    run_op(OP_STEP, MODE_ALWAYS, 1'b0, 8'h00, 16'h0000, 16'h0002, 16'h0003, 1'b0, "step3");
  endtask

  task automatic test_conditions();
    sif.rx_input_flags = 8'h05;
    run_op(OP_JUMP, MODE_ANY,  1'b0, 8'h04, 16'h1234, 16'h0003, 16'h1234, 1'b1, "any_true");
    run_op(OP_JUMP, MODE_ALL,  1'b0, 8'h06, 16'h4000, 16'h1234, 16'h1235, 1'b0, "all_false");
    run_op(OP_JUMP, MODE_NONE, 1'b0, 8'h0A, 16'h2000, 16'h1235, 16'h2000, 1'b1, "none_true");
    run_op(OP_JUMP, MODE_ALL,  1'b0, 8'h00, 16'h3000, 16'h2000, 16'h3000, 1'b1, "all_mask0");
    run_op(OP_JUMP, MODE_ANY,  1'b0, 8'h0A, 16'h5000, 16'h3000, 16'h3001, 1'b0, "any_false");
    run_op(OP_CALL, MODE_NONE, 1'b0, 8'h01, 16'h6000, 16'h3001, 16'h3002, 1'b0, "call_false");
  endtask

  task automatic test_wrap();
    run_op(OP_JUMP, MODE_ALWAYS, 1'b0, 8'h00, 16'hFFFF, 16'h3002, 16'hFFFF, 1'b1, "jump_ffff");
    run_op(OP_STEP, MODE_ALWAYS, 1'b0, 8'h00, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, "step_wrap");
    run_op(OP_JUMP, MODE_ALWAYS, 1'b0, 8'h00, 16'h0010, 16'h0000, 16'h0010, 1'b1, "jump_0010");
    run_op(OP_JUMP, MODE_ALWAYS, 1'b1, 8'h00, 16'hFFF0, 16'h0010, 16'h0000, 1'b1, "rel_wrap");
    run_op(OP_JUMP, MODE_ALWAYS, 1'b1, 8'h00, 16'h0005, 16'h0000, 16'h0005, 1'b1, "rel_fwd");
  endtask

  task automatic test_stack();
    run_op(OP_CALL, MODE_ALWAYS, 1'b0, 8'h00, 16'h0100, 16'h0005, 16'h0100, 1'b1, "call1");
    run_op(OP_CALL, MODE_ALWAYS, 1'b0, 8'h00, 16'h0200, 16'h0100, 16'h0200, 1'b1, "call2");
    run_op(OP_CALL, MODE_ALWAYS, 1'b0, 8'h00, 16'h0300, 16'h0200, 16'h0300, 1'b1, "call3");
    run_op(OP_CALL, MODE_ALWAYS, 1'b0, 8'h00, 16'h0400, 16'h0300, 16'h0400, 1'b1, "call4");
    n_checks++;
    if (sif.tx_overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_early: got %b expected 0", sif.tx_overflow);
    end
    run_op(OP_CALL, MODE_ALWAYS, 1'b0, 8'h00, 16'h0500, 16'h0400, 16'h0401, 1'b0, "call5_full");
    n_checks++;
    if (sif.tx_overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set: got %b expected 1", sif.tx_overflow);
    end
    run_op(OP_RET, MODE_ALWAYS, 1'b0, 8'h00, 16'h0000, 16'h0401, 16'h0301, 1'b1, "ret1");
    run_op(OP_RET, MODE_NONE,   1'b0, 8'hFF, 16'h7777, 16'h0301, 16'h0201, 1'b1, "ret2");
    run_op(OP_RET, MODE_ALWAYS, 1'b0, 8'h00, 16'h0000, 16'h0201, 16'h0101, 1'b1, "ret3");
    run_op(OP_RET, MODE_ALWAYS, 1'b0, 8'h00, 16'h0000, 16'h0101, 16'h0006, 1'b1, "ret4");
    n_checks++;
    if (sif.tx_underflow !== 1'b0) begin
      n_fail++; $display("FAIL unf_early: got %b expected 0", sif.tx_underflow);
    end
    run_op(OP_RET, MODE_ALWAYS, 1'b0, 8'h00, 16'h0000, 16'h0006, 16'h0007, 1'b0, "ret5_empty");
    n_checks++;
    if (sif.tx_underflow !== 1'b1 || sif.tx_overflow !== 1'b1) begin
      n_fail++; $display("FAIL sticky: unf %b ovf %b expected 1 1", sif.tx_underflow, sif.tx_overflow);
    end
  endtask

  task automatic test_ignore_strobe();
    @(negedge aclk);
    sif.rx_strobe = 1'b1; sif.rx_op = OP_STEP; sif.rx_mode = MODE_ALWAYS; sif.rx_relative = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    sif.rx_op = OP_JUMP; sif.rx_target = 16'h5555;
    @(negedge aclk);
    sif.rx_strobe = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    n_checks++;
    if (sif.tx_program_counter !== 16'h0008 || sif.tx_ready !== 1'b1) begin
      n_fail++; $display("FAIL ignore_commit: pc %h ready %b expected 0008 1", sif.tx_program_counter, sif.tx_ready);
    end
    repeat (4) @(negedge aclk);
    n_checks++;
    if (sif.tx_program_counter !== 16'h0008 || sif.tx_ready !== 1'b1) begin
      n_fail++; $display("FAIL ignore_later: pc %h ready %b expected 0008 1", sif.tx_program_counter, sif.tx_ready);
    end
  endtask

  task automatic test_enable_freeze();
    @(negedge aclk);
    sif.rx_strobe = 1'b1; sif.rx_op = OP_STEP; sif.rx_mode = MODE_ALWAYS;
    @(posedge aclk);
    @(negedge aclk);
    sif.rx_strobe = 1'b0;
    sif.rx_enable = 1'b0;
    repeat (5) @(posedge aclk);
    @(negedge aclk);
    n_checks++;
    if (sif.tx_ready !== 1'b0 || sif.tx_program_counter !== 16'h0008) begin
      n_fail++; $display("FAIL freeze_hold: ready %b pc %h expected 0 0008", sif.tx_ready, sif.tx_program_counter);
    end
    sif.rx_enable = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    n_checks++;
    if (sif.tx_program_counter !== 16'h0008 || sif.tx_ready !== 1'b0) begin
      n_fail++; $display("FAIL freeze_early: pc %h ready %b expected 0008 0", sif.tx_program_counter, sif.tx_ready);
    end
    @(negedge aclk);
    n_checks++;
    if (sif.tx_program_counter !== 16'h0009 || sif.tx_ready !== 1'b1) begin
      n_fail++; $display("FAIL freeze_commit: pc %h ready %b expected 0009 1", sif.tx_program_counter, sif.tx_ready);
    end
    repeat (3) @(negedge aclk);
    n_checks++;
    if (sif.tx_program_counter !== 16'h0009) begin
      n_fail++; $display("FAIL freeze_single: pc %h expected 0009", sif.tx_program_counter);
    end
  endtask

  task automatic test_reset_mid_commit();
    @(negedge aclk);
    sif.rx_strobe = 1'b1; sif.rx_op = OP_CALL; sif.rx_mode = MODE_ALWAYS; sif.rx_relative = 1'b0;
    sif.rx_target = 16'h0700;
    @(posedge aclk);
    @(negedge aclk);
    sif.rx_strobe = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    n_checks++;
    if (sif.tx_program_counter !== 16'h0000 || sif.tx_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_pc: pc %h ready %b expected 0000 1", sif.tx_program_counter, sif.tx_ready);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      n_checks++;
      if (sif.tx_taken !== 1'b0 || sif.tx_program_counter !== 16'h0000) begin
        n_fail++; $display("FAIL abort_quiet%0d: taken %b pc %h expected 0 0000", i, sif.tx_taken, sif.tx_program_counter);
      end
    end
    n_checks++;
    if (sif.tx_overflow !== 1'b0 || sif.tx_underflow !== 1'b0) begin
      n_fail++; $display("FAIL abort_sticky: ovf %b unf %b expected 0 0", sif.tx_overflow, sif.tx_underflow);
    end
    run_op(OP_RET, MODE_ALWAYS, 1'b0, 8'h00, 16'h0000, 16'h0000, 16'h0001, 1'b0, "abort_ret");
    n_checks++;
    if (sif.tx_underflow !== 1'b1) begin
      n_fail++; $display("FAIL abort_stack_empty: unf %b expected 1", sif.tx_underflow);
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_conditions();
    test_wrap();
    test_stack();
    test_ignore_strobe();
    test_enable_freeze();
    test_reset_mid_commit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
